// File: rtl/merge_pkg.sv
// Shared definitions for the serial-to-parallel word assembler.
package merge_pkg;

    localparam int MSB_FIRST_MODE = 0;
    localparam int LSB_FIRST_MODE = 1;

    localparam int CH_W_MAX = 4;
    typedef logic [CH_W_MAX-1:0] ch_idx_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// Shift register, bit counter and completion strobe for one serial word.
module sipo_shift
    import merge_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int LSB_FIRST = MSB_FIRST_MODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_i,
    input  logic              bit_valid_i,
    input  logic              sync_i,
    output logic              done_o,
    output logic [WORD_W-1:0] word_o
);

    localparam int CNT_W = clog2_min1(WORD_W);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              last_bit;

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        last_bit = (cnt_q == CNT_W'(WORD_W - 1));
        if (bit_valid_i) begin
            if (LSB_FIRST == LSB_FIRST_MODE)
                shift_d = {bit_i, shift_q[WORD_W-1:1]};
            else
                shift_d = {shift_q[WORD_W-2:0], bit_i};
        end
        // sync realigns; a coincident bit becomes bit 0 of the new word
        if (sync_i)
            cnt_d = bit_valid_i ? CNT_W'(1) : '0;
        else if (bit_valid_i)
            cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
        done_o = bit_valid_i && last_bit && !sync_i;
        word_o = shift_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/merge_data_stream.sv
// Serial-to-parallel word assembler with channel tagging, valid/ready output and sticky overflow.
module merge_data_stream
    import merge_pkg::*;
#(
    parameter  int WORD_W    = 32,
    parameter  int NUM_CH    = 2,
    parameter  int LSB_FIRST = MSB_FIRST_MODE,
    localparam int CH_W      = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_i,
    input  logic                     bit_valid_i,
    input  logic                     sync_i,
    output logic signed [WORD_W-1:0] word_o,
    output logic [CH_W-1:0]          ch_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     overflow_o,
    input  logic                     ovf_clr_i
);

    logic              done;
    logic [WORD_W-1:0] shift_word;

    sipo_shift #(
        .WORD_W    (WORD_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_sipo (
        .clk         (clk),
        .rst         (rst),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .sync_i      (sync_i),
        .done_o      (done),
        .word_o      (shift_word)
    );

    ch_idx_t           ch_cnt_q, ch_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              load, drop;

    always_comb begin
        ch_cnt_d = ch_cnt_q;
        word_d   = word_q;
        ch_d     = ch_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        load     = done && (!valid_q || ready_i);
        drop     = done && valid_q && !ready_i;

        // channel advances even on drops so interleave alignment survives
        if (sync_i)
            ch_cnt_d = '0;
        else if (done)
            ch_cnt_d = (ch_cnt_q == ch_idx_t'(NUM_CH - 1)) ? '0 : ch_cnt_q + ch_idx_t'(1);

        if (load) begin
            word_d  = shift_word;
            ch_d    = ch_cnt_q[CH_W-1:0];
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (drop)
            ovf_d = 1'b1;
        else if (ovf_clr_i)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_q <= '0;
            word_q   <= '0;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ch_cnt_q <= ch_cnt_d;
            word_q   <= word_d;
            ch_q     <= ch_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign word_o     = word_q;
    assign ch_o       = ch_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_merge_data_stream.sv
// Directed bench: MSB-first 32-bit/2-channel instance plus LSB-first 16-bit/1-channel instance.
module tb_merge_data_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        bit_i = 1'b0, bit_valid_i = 1'b0, sync_i = 1'b0;
    logic        ready_i = 1'b1, ovf_clr_i = 1'b0;
    logic [31:0] word_o;
    logic [0:0]  ch_o;
    logic        valid_o, overflow_o;

    logic        l_bit = 1'b0, l_bv = 1'b0;
    logic [15:0] l_word;
    logic [0:0]  l_ch;
    logic        l_valid, l_ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    merge_data_stream #(.WORD_W(32), .NUM_CH(2), .LSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i), .sync_i(sync_i),
        .word_o(word_o), .ch_o(ch_o), .valid_o(valid_o), .ready_i(ready_i),
        .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i)
    );

    merge_data_stream #(.WORD_W(16), .NUM_CH(1), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .bit_i(l_bit), .bit_valid_i(l_bv), .sync_i(1'b0),
        .word_o(l_word), .ch_o(l_ch), .valid_o(l_valid), .ready_i(1'b1),
        .overflow_o(l_ovf), .ovf_clr_i(1'b0)
    );

    typedef struct {
        logic [31:0] data;
        logic        exp_ch;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        bit_i = b; bit_valid_i = 1'b1; sync_i = s;
        tick();
        bit_valid_i = 1'b0; sync_i = 1'b0;
    endtask

    task automatic send_msb(input logic [31:0] w, input int from, input int to);
        for (int i = from; i <= to; i++) send_bit(w[31-i], 1'b0);
    endtask

    task automatic tick_l();
        tick();
        if (l_valid) pulses++;
    endtask

    task automatic send_lsb(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick_l();
            l_bit = w[i]; l_bv = 1'b1;
            tick_l();
            l_bv = 1'b0;
        end
    endtask

    initial begin
        tbl[0] = '{32'h12345678, 1'b0};
        tbl[1] = '{32'hFEDCBA98, 1'b1};
        tbl[2] = '{32'h80000000, 1'b0};
        tbl[3] = '{32'h7FFFFFFF, 1'b1};

        tick(); tick();
        chk("rst_word", word_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ch", ch_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rst = 1'b0;
        tick();

        // continuous MSB-first words with ready held high
        for (int v = 0; v < 4; v++) begin
            send_msb(tbl[v].data, 0, 30);
            chk($sformatf("tbl%0d_pre_valid", v), valid_o, 0);
            send_msb(tbl[v].data, 31, 31);
            chk($sformatf("tbl%0d_valid", v), valid_o, 1);
            chk($sformatf("tbl%0d_word", v), word_o, tbl[v].data);
            chk($sformatf("tbl%0d_ch", v), ch_o, tbl[v].exp_ch);
            tick();
            chk($sformatf("tbl%0d_valid_clr", v), valid_o, 0);
        end
        chk("tbl_ovf", overflow_o, 0);

        // backpressure: B dropped, still consumes channel 1
        ready_i = 1'b0;
        send_msb(32'h00000001, 0, 31);
        chk("bp_a_word", word_o, 32'h1);
        chk("bp_a_ch", ch_o, 0);
        send_msb(32'h00000002, 0, 31);
        chk("bp_hold_word", word_o, 32'h1);
        chk("bp_hold_valid", valid_o, 1);
        chk("bp_ovf", overflow_o, 1);
        ready_i = 1'b1;
        tick();
        chk("bp_accept_valid", valid_o, 0);
        send_msb(32'h00000003, 0, 31);
        chk("bp_c_word", word_o, 32'h3);
        chk("bp_c_ch", ch_o, 0);
        chk("bp_ovf_sticky", overflow_o, 1);
        tick();
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("ovf_clr", overflow_o, 0);

        // back-to-back: ready rises exactly on B's last bit
        ready_i = 1'b0;
        send_msb(32'h00000011, 0, 31);
        chk("b2b_a_word", word_o, 32'h11);
        chk("b2b_a_ch", ch_o, 1);
        send_msb(32'h00000022, 0, 30);
        ready_i = 1'b1;
        send_msb(32'h00000022, 31, 31);
        chk("b2b_valid", valid_o, 1);
        chk("b2b_word", word_o, 32'h22);
        chk("b2b_ch", ch_o, 0);
        chk("b2b_ovf", overflow_o, 0);
        tick();
        chk("b2b_valid_clr", valid_o, 0);

        // sync on a completing bit discards that word
        send_msb(32'hDEADBEEF, 0, 30);
        send_bit(1'b1, 1'b1);
        chk("sync_done_valid", valid_o, 0);
        chk("sync_done_ovf", overflow_o, 0);

        // re-sync after garbage; hold the word for the reset test
        send_msb(32'hFFC00000, 0, 9);
        ready_i = 1'b0;
        send_bit(1'b1, 1'b1);
        send_msb(32'hA5A5A5A5, 1, 31);
        chk("resync_valid", valid_o, 1);
        chk("resync_word", word_o, 32'hA5A5A5A5);
        chk("resync_ch", ch_o, 0);
        chk("resync_ovf", overflow_o, 0);

        // async reset mid-word clears outputs without a clock edge
        send_msb(32'h0F0F0F0F, 0, 20);
        rst = 1'b1;
        #2;
        chk("arst_valid", valid_o, 0);
        chk("arst_word", word_o, 0);
        chk("arst_ch", ch_o, 0);
        #2;
        rst = 1'b0;
        tick();
        ready_i = 1'b1;
        send_msb(32'h0F0F1234, 0, 31);
        chk("post_rst_valid", valid_o, 1);
        chk("post_rst_word", word_o, 32'h0F0F1234);
        chk("post_rst_ch", ch_o, 0);
        tick();

        // LSB-first instance with random gaps
        pulses = 0;
        send_lsb(16'h8001);
        chk("lsb_valid", l_valid, 1);
        chk("lsb_word", l_word, 16'h8001);
        chk("lsb_ch", l_ch, 0);
        tick_l();
        chk("lsb_valid_clr", l_valid, 0);
        chk("lsb_pulses", pulses, 1);
        send_lsb(16'h7FFE);
        chk("lsb_word2", l_word, 16'h7FFE);
        chk("lsb_ovf", l_ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/merge_data_stream.md
Name: merge_data_stream

Overview:
Parametrised serial-to-parallel word assembler, the successor of the single-channel 32-bit merge stage in the UART streaming front end of the FM demodulator.
- Collects a qualified 1-bit stream into WORD_W-bit signed words.
- Supports MSB-first or LSB-first ordering and NUM_CH interleaved channels (e.g. I/Q).
- Adds frame re-sync, a valid/ready output handshake and sticky overflow reporting.

Parameters:
WORD_W, 32, bits per assembled word (2..64)
NUM_CH, 2, interleaved channels per frame (1..16)
LSB_FIRST, 0, 0: first received bit lands in word_o MSB; 1: first bit lands in bit 0
CH_W, $clog2(NUM_CH) min 1, channel index width (derived, not overridden)

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
bit_i  in  1  serial data bit from UART streaming
bit_valid_i  in  1  bit_i is valid this cycle
sync_i  in  1  frame start; realigns bit and channel counters
word_o  out  WORD_W  assembled word, signed two's complement
ch_o  out  CH_W  channel index of word_o
valid_o  out  1  word_o/ch_o valid
ready_i  in  1  consumer accepts word when valid_o && ready_i
overflow_o  out  1  sticky: at least one completed word was dropped
ovf_clr_i  in  1  clears overflow_o

Behaviour:
Reset: word_o=0, ch_o=0, valid_o=0, overflow_o=0, bit counter=0, channel counter=0, shift register=0.

Bit capture:
- On bit_valid_i, shift bit_i into the shift register. MSB-first shifts toward the MSB; LSB_FIRST shifts toward the LSB. The bit counter then increments.
- Cycles without bit_valid_i are ignored; gaps of any length are allowed.

Word completion:
- Completion is the cycle with bit_valid_i=1 and bit counter=WORD_W-1.
- The bit counter wraps to 0.
- The completed word, including that bit, is offered to the output register.
- Latency: valid_o rises on the clock edge that samples the last bit, so it is visible in the next cycle.

Output register:
- Loads the word and the current channel counter if valid_o=0, or if valid_o && ready_i in the same cycle (back-to-back: valid_o stays 1 with the new word).
- Otherwise (valid_o=1, ready_i=0) the new word is dropped, overflow_o is set, and the held word is unchanged.
- valid_o clears on valid_o && ready_i with no simultaneous completion.
- word_o/ch_o stay stable while valid_o && !ready_i.

Channel counter:
- Increments on every completion, including dropped words, so channel alignment is kept.
- Wraps at NUM_CH-1 to 0.
- With NUM_CH=1, ch_o is constant 0.

sync_i:
- Clears the bit and channel counters. If bit_valid_i is also 1 in that cycle, that bit is bit 0 of the new word (counter becomes 1).
- A partially collected word is discarded silently; it does not count as overflow.
- sync_i coincident with a completion: sync_i wins and the word is discarded.
- sync_i does not affect valid_o, word_o or overflow_o.

overflow_o:
- Set on a drop; cleared by ovf_clr_i.
- A drop in the same cycle as ovf_clr_i leaves it set (set wins).

Reset mid-word: all state cleared asynchronously; collection restarts at bit 0 and channel 0 after rst deasserts.

Decomposition:
- Shared package merge_pkg: clog2-based width function; channel index typedef; LSB_FIRST mode constants.
- One natural sub-module, sipo_shift: shift register, bit counter and completion strobe, parametrised by WORD_W/LSB_FIRST.
- The top level holds the channel counter, output register, handshake and overflow logic.

Test Plan:
- MSB-first, WORD_W=32, NUM_CH=2, ready_i=1: send 0x12345678 then 0xFEDCBA98 MSB first with continuous bit_valid_i -> word_o=0x12345678, ch_o=0, valid_o the cycle after bit 31; then 0xFEDCBA98 (negative), ch_o=1.
- LSB_FIRST=1, WORD_W=16: send 0x8001 LSB first with random bit_valid_i gaps -> word_o=0x8001, one valid_o pulse.
- Backpressure: ready_i=0, complete words A=0x00000001 and B=0x00000002 -> word_o holds A, overflow_o=1 after B; the next word C arrives with ch_o=0 (B consumed ch 1); ovf_clr_i -> overflow_o=0.
- Back-to-back: ready_i asserted exactly on B's completion cycle while A is held -> A accepted, B loaded, valid_o stays 1, overflow_o=0.
- Re-sync: 10 bits of garbage, then sync_i together with the first bit of 0xA5A5A5A5 -> word_o=0xA5A5A5A5, ch_o=0, no overflow.
- Async rst pulse mid-word (after bit 20) -> all outputs 0 immediately; the next full word is assembled correctly with ch_o=0.
